// File: rtl/pn_arbiter.sv
// Two-requester round-robin front end for a single PN expression engine.
// Optional WAIT watchdog enabled by defining PN_ARB_TIMEOUT_EN.
module pn_arbiter #(
    parameter int MAX_TOK = 12,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  tok_valid,
    input  logic [3:0]  tok_mode,
    input  logic [1:0]  tok_op,
    input  logic [5:0]  tok_in,
    input  logic [1:0]  tok_last,
    output logic [1:0]  pn_mode,
    output logic        pn_operator,
    output logic [2:0]  pn_in,
    output logic        pn_in_valid,
    input  logic        pn_out_valid,
    input  logic [31:0] pn_out,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, FEED, WAIT, COOL} state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_TOK);

    state_t      r_state, w_next;
    logic        r_ptr;
    logic [1:0]  r_gnt;
    logic [3:0]  r_tcnt, r_exp, r_rcnt;
    logic        r_cool;
    logic [1:0]  r_pn_mode;
    logic        r_pn_op;
    logic [2:0]  r_pn_in;
    logic        r_pn_in_valid;
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_last;

    logic        w_sel, w_tv, w_top, w_tlast;
    logic [1:0]  w_tmode, w_fmode, w_pick;
    logic [2:0]  w_tin;
    logic [3:0]  w_tcnt_nx, w_fcnt, w_div, w_exp;
    logic        w_feed_end, w_rsp_done, w_to, w_wait_end;

    assign w_sel     = r_gnt[1];
    assign w_tv      = w_sel ? tok_valid[1]  : tok_valid[0];
    assign w_top     = w_sel ? tok_op[1]     : tok_op[0];
    assign w_tlast   = w_sel ? tok_last[1]   : tok_last[0];
    assign w_tmode   = w_sel ? tok_mode[3:2] : tok_mode[1:0];
    assign w_tin     = w_sel ? tok_in[5:3]   : tok_in[2:0];
    assign w_tcnt_nx = r_tcnt + 4'd1;
    assign w_pick    = (req == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : req;

    // A single-token job must use the mode arriving with that token
    assign w_fmode = (r_tcnt == 4'd0) ? w_tmode : r_pn_mode;
    assign w_fcnt  = w_tv ? w_tcnt_nx : r_tcnt;
    assign w_div   = w_fcnt / 4'd3;
    assign w_exp   = (w_fmode[1] || w_div == 4'd0) ? 4'd1 : w_div;

    assign w_feed_end = (r_state == FEED) &&
                        ((w_tv && (w_tlast || w_tcnt_nx == LP_MAX)) ||
                         (!w_tv && r_tcnt != 4'd0));
    assign w_rsp_done = (r_state == WAIT) && pn_out_valid &&
                        (r_rcnt + 4'd1 == r_exp);
    assign w_wait_end = w_rsp_done || w_to;

`ifdef PN_ARB_TIMEOUT_EN
    localparam int LP_WDW = $clog2(TIMEOUT + 1);
    localparam logic [LP_WDW-1:0] LP_WDLIM = LP_WDW'(TIMEOUT - 1);

    logic [LP_WDW-1:0] r_wd;

    assign w_to = (r_state == WAIT) && !pn_out_valid && (r_wd == LP_WDLIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wd <= '0;
        else if (r_state != WAIT || pn_out_valid)
            r_wd <= '0;
        else
            r_wd <= r_wd + 1'b1;
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (|req)      w_next = FEED;
            FEED: if (w_feed_end) w_next = WAIT;
            WAIT: if (w_wait_end) w_next = COOL;
            COOL: if (r_cool)     w_next = IDLE;
            default:              w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= 1'b0;
            r_gnt         <= 2'b00;
            r_tcnt        <= 4'd0;
            r_exp         <= 4'd0;
            r_rcnt        <= 4'd0;
            r_cool        <= 1'b0;
            r_pn_mode     <= 2'b00;
            r_pn_op       <= 1'b0;
            r_pn_in       <= 3'd0;
            r_pn_in_valid <= 1'b0;
            r_rsp_valid   <= 2'b00;
            r_rsp_data    <= 32'd0;
            r_rsp_last    <= 1'b0;
        end else begin
            r_pn_in_valid <= 1'b0;
            r_rsp_valid   <= 2'b00;
            r_rsp_last    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt  <= w_pick;
                        r_tcnt <= 4'd0;
                        r_rcnt <= 4'd0;
                        r_cool <= 1'b0;
                    end
                end
                FEED: begin
                    if (w_tv) begin
                        r_pn_in_valid <= 1'b1;
                        r_pn_op       <= w_top;
                        r_pn_in       <= w_tin;
                        r_tcnt        <= w_tcnt_nx;
                        if (r_tcnt == 4'd0)
                            r_pn_mode <= w_tmode;
                    end
                    if (w_feed_end)
                        r_exp <= w_exp;
                end
                WAIT: begin
                    if (pn_out_valid) begin
                        r_rsp_valid <= r_gnt;
                        r_rsp_data  <= pn_out;
                        r_rsp_last  <= w_rsp_done;
                        r_rcnt      <= r_rcnt + 4'd1;
                    end else if (w_to) begin
                        r_rsp_valid <= r_gnt;
                        r_rsp_data  <= 32'h8000_0000;
                        r_rsp_last  <= 1'b1;
                    end
                end
                COOL: begin
                    r_cool <= 1'b1;
                    if (r_cool) begin
                        r_gnt  <= 2'b00;
                        r_ptr  <= ~r_ptr;
                        r_cool <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign pn_mode     = r_pn_mode;
    assign pn_operator = r_pn_op;
    assign pn_in       = r_pn_in;
    assign pn_in_valid = r_pn_in_valid;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign busy        = (r_state != IDLE);
endmodule

// File: doc/pn_arbiter.md
PN_ARBITER -- requirements
Module: pn_arbiter

Interface
REQ-001 Parameter: MAX_TOK, 12, maximum tokens per expression.
REQ-002 Parameter: TIMEOUT, 64, watchdog limit in cycles (used only with PN_ARB_TIMEOUT_EN).
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  2  per-requester job request, bit i = requester i.
REQ-006 Port: gnt  out  2  one-hot grant, held for the whole job.
REQ-007 Port: tok_valid  in  2  per-requester token strobe.
REQ-008 Port: tok_mode  in  4  per-requester mode, bits [2i+1:2i].
REQ-009 Port: tok_op  in  2  per-requester operator flag.
REQ-010 Port: tok_in  in  6  per-requester token value, bits [3i+2:3i].
REQ-011 Port: tok_last  in  2  per-requester last-token marker.
REQ-012 Port: pn_mode  out  2  mode to the PN engine.
REQ-013 Port: pn_operator  out  1  operator flag to the engine.
REQ-014 Port: pn_in  out  3  token value to the engine.
REQ-015 Port: pn_in_valid  out  1  token strobe to the engine.
REQ-016 Port: pn_out_valid  in  1  engine result strobe.
REQ-017 Port: pn_out  in  32  engine result, signed.
REQ-018 Port: rsp_valid  out  2  per-requester result strobe.
REQ-019 Port: rsp_data  out  32  result data, shared by both requesters.
REQ-020 Port: rsp_last  out  1  marks the final result of a job.
REQ-021 Port: busy  out  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL use states IDLE, FEED, WAIT, COOL; reset state IDLE.
REQ-023 In IDLE with any req bit high, the block SHALL latch a one-hot grant in gnt and enter FEED on the next edge.
REQ-024 Arbitration SHALL be round-robin with a 1-bit priority pointer (reset 0): on simultaneous requests the pointed requester wins; the pointer SHALL move to the other requester when a job completes (COOL exit).
REQ-025 A single requester SHALL be granted regardless of the pointer.
REQ-026 In FEED, each granted tok_valid cycle SHALL be registered to pn_* with 1-cycle latency; tok_mode SHALL be captured from the first token only and held on pn_mode for the job.
REQ-027 Tokens and tok_valid from the non-granted requester SHALL be ignored.
REQ-028 A 4-bit token counter SHALL increment per forwarded token; FEED SHALL end after a token with tok_last=1, after the MAX_TOK-th token, or on the first granted cycle with tok_valid=0 after at least one token (gap = implicit end).
REQ-029 Expected result count SHALL be: mode 0/1 -> max(1, count/3) (integer division); mode 2/3 -> 1.
REQ-030 In WAIT, each pn_out_valid SHALL produce a 1-cycle rsp_valid on the granted bit with rsp_data=pn_out, registered, latency 1 cycle.
REQ-031 rsp_last SHALL be high with the response whose index equals expected count; WAIT SHALL then go to COOL.
REQ-032 pn_out_valid outside WAIT SHALL be discarded.
REQ-033 COOL SHALL last exactly 2 cycles, then clear gnt and return to IDLE; a request pending at COOL exit SHALL be arbitrated in IDLE on the following cycle.
REQ-034 pn_in_valid SHALL be 0 in every state other than FEED and the cycle after its last forwarded token.

Reset
REQ-035 rst_n low SHALL asynchronously force: state IDLE, gnt=0, pn_mode=0, pn_operator=0, pn_in=0, pn_in_valid=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, pointer=0, counters=0.
REQ-036 Reset mid-job SHALL drop the job without any response.

Configuration
REQ-037 With PN_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT, clear on each pn_out_valid, and on reaching TIMEOUT SHALL emit one rsp_valid on the granted bit with rsp_data=32'h8000_0000 and rsp_last=1, then enter COOL.
REQ-038 Without PN_ARB_TIMEOUT_EN, WAIT SHALL hold indefinitely until the expected count of results arrives; no counter is present.

Verification
REQ-039 req=2'b01, tokens (op,in) (1,0)(0,3)(0,4) mode 0 last on 3rd -> pn_in_valid 3 cycles, one response 7 on rsp_valid[0] with rsp_last=1.
REQ-040 req=2'b11 after reset -> gnt=2'b01 first; after COOL, gnt=2'b10; third job goes to requester 0 again.
REQ-041 Mode 1, 6 tokens, no tok_last, then tok_valid low -> expected count 2; two rsp_valid pulses, rsp_last on second only.
REQ-042 Requester 1 streams tokens while requester 0 is granted -> pn_in unaffected, no rsp_valid[1].
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 within same cycle, no response after release, next req granted normally.
REQ-044 With PN_ARB_TIMEOUT_EN, engine never asserts pn_out_valid -> after 64 WAIT cycles rsp_data=32'h8000_0000, rsp_last=1, busy low 2 cycles later.
